// File: rtl/match_capture.sv
// Match/sample capture: ORs LANES result words, masks against a programmable target,
// and queues hits and one-shot samples into a first-word-fall-through FIFO for the host.

module mc_lane_or #(
  parameter int W = 32
) (
  input  logic [W-1:0] acc_in,
  input  logic [W-1:0] lane,
  output logic [W-1:0] acc_out
);
  assign acc_out = acc_in | lane;
endmodule

module match_capture #(
  parameter int ID         = 0,
  parameter int LANES      = 4,
  parameter int DATA_W     = 20,
  parameter int DEPTH      = 16,
  parameter int RESET_MASK = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LANES*32-1:0]   result,
  input  logic                  result_valid,
  input  logic [DATA_W-1:0]     data,
  input  logic [4:0]            cycle,
  input  logic                  cmd_strobe,
  input  logic [19:0]           cmd,
  input  logic [2:0]            opcode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W+7:0]     out_data,
  output logic [7:0]            drop_count
);
  localparam int AW     = $clog2(DEPTH);
  localparam int STAGES = 2;
  localparam logic [5:0] RST_LEN = 6'(RESET_MASK);

  typedef struct packed {
    logic [31:0]       r;
    logic [4:0]        cyc;
    logic [DATA_W-1:0] data;
  } res_t;

  typedef struct packed {
    logic              ovf;
    logic              sample;
    logic              match;
    logic [4:0]        cyc;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Lengths above 32 clamp; length 0 gives an all-zero mask so every result matches.
  function automatic logic [31:0] len2mask(input logic [5:0] len);
    logic [5:0] l;
    l = (len > 6'd32) ? 6'd32 : len;
    return (l == 6'd0) ? 32'h0 : (32'hFFFF_FFFF << (6'd32 - l));
  endfunction

  // ---------------- command path ----------------
  logic [2:0]  strb_sync;
  logic        cmd_det, cmd_vld;
  logic [15:0] cmd_q;
  logic [2:0]  op_q;
  wire         unused_cmd_hi = ^cmd[19:16];

  assign cmd_det = strb_sync[1] ^ strb_sync[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strb_sync <= '0;
      cmd_vld   <= 1'b0;
      cmd_q     <= '0;
      op_q      <= '0;
    end else begin
      strb_sync <= {strb_sync[1:0], cmd_strobe};
      cmd_vld   <= cmd_det;
      if (cmd_det) begin
        cmd_q <= cmd[15:0];
        op_q  <= opcode;
      end
    end
  end

  logic [31:0] target, mask;
  logic        armed;
  logic [4:0]  arm_cycle;
  logic        arm_wr, sample_hit, hit;

  assign arm_wr = cmd_vld && (op_q == 3'd7) && (cmd_q[15:8] == 8'(ID));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target    <= '0;
      mask      <= len2mask(RST_LEN);
      armed     <= 1'b0;
      arm_cycle <= '0;
    end else begin
      if (cmd_vld) begin
        case (op_q)
          3'd0:    target[15:0]  <= cmd_q;
          3'd1:    target[31:16] <= cmd_q;
          3'd2:    mask          <= len2mask(cmd_q[5:0]);
          default: ;
        endcase
      end
      // A re-arm landing on the sampling cycle takes priority over the auto-disarm.
      if (arm_wr) begin
        arm_cycle <= cmd_q[4:0];
        armed     <= cmd_q[6];
      end else if (sample_hit) begin
        armed <= 1'b0;
      end
    end
  end

  // ---------------- match pipeline ----------------
  logic [LANES:0][31:0] or_chain;
  assign or_chain[0] = '0;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mc_lane_or #(.W(32)) u_or (
      .acc_in  (or_chain[i]),
      .lane    (result[32*i +: 32]),
      .acc_out (or_chain[i+1])
    );
  end

  logic [STAGES:1] vld_pipe;
  res_t            s1, s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], result_valid};
      s1       <= '{r: or_chain[LANES], cyc: cycle, data: data};
      s2       <= s1;
    end
  end

  assign hit        = vld_pipe[STAGES] && ((s2.r & mask) == (target & mask));
  assign sample_hit = vld_pipe[STAGES] && armed && (s2.cyc == arm_cycle);

  // ---------------- capture FIFO ----------------
  entry_t      mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic        empty, full, push, pop, accept, drop, ovf_pending;
  entry_t      new_e;

  assign empty  = (wptr == rptr);
  assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign push   = hit | sample_hit;
  assign pop    = !empty && out_ready;
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;
  assign new_e  = '{ovf: ovf_pending, sample: sample_hit, match: hit,
                    cyc: s2.cyc, data: s2.data};

  always_ff @(posedge clk) begin
    if (accept) mem[wptr[AW-1:0]] <= new_e;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr        <= '0;
      rptr        <= '0;
      ovf_pending <= 1'b0;
      drop_count  <= '0;
    end else begin
      if (accept) wptr <= wptr + 1'b1;
      if (pop)    rptr <= rptr + 1'b1;
      // The first entry accepted after a loss carries the overflow flag.
      if (accept)    ovf_pending <= 1'b0;
      else if (drop) ovf_pending <= 1'b1;
      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem[rptr[AW-1:0]];

endmodule

// File: tb/tb_match_capture.sv
// Directed bench for match_capture: stimulus pushes expected FIFO entries into a queue,
// a negedge monitor pops and compares on every host handshake.

module tb_match_capture;
  localparam int ID = 0, LANES = 4, DATA_W = 20, DEPTH = 16, EW = DATA_W + 8;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [LANES*32-1:0] result = '0;
  logic                result_valid = 1'b0;
  logic [DATA_W-1:0]   data = '0;
  logic [4:0]          cycle = '0;
  logic                cmd_strobe = 1'b0;
  logic [19:0]         cmd = '0;
  logic [2:0]          opcode = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [EW-1:0]       out_data;
  logic [7:0]          drop_count;

  int            total = 0, bad = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_exp;

  always #5 clk = ~clk;

  match_capture #(.ID(ID), .LANES(LANES), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_MASK(32)) dut (
    .clk(clk), .rst_n(rst_n), .result(result), .result_valid(result_valid), .data(data),
    .cycle(cycle), .cmd_strobe(cmd_strobe), .cmd(cmd), .opcode(opcode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .drop_count(drop_count)
  );

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_entry got=%h required=none", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_data !== mon_exp) begin
          bad++;
          $display("FAIL entry got=%h required=%h", out_data, mon_exp);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%h required=%h", nm, act, req);
    end
  endtask

  function automatic logic [EW-1:0] ent(input logic ovf, input logic s, input logic m,
                                        input logic [4:0] cy, input logic [DATA_W-1:0] d);
    return {ovf, s, m, cy, d};
  endfunction

  function automatic logic [LANES*32-1:0] ln(input int i, input logic [31:0] v);
    logic [LANES*32-1:0] x;
    x = '0;
    x[32*i +: 32] = v;
    return x;
  endfunction

  // Commands are spaced 8 clocks apart, cmd set one clock ahead of the toggle.
  task automatic do_cmd(input logic [2:0] op, input logic [19:0] c);
    opcode = op;
    cmd    = c;
    tick();
    cmd_strobe = ~cmd_strobe;
    tick(7);
  endtask

  task automatic send(input logic [LANES*32-1:0] r, input logic [4:0] cy,
                      input logic [DATA_W-1:0] d, input logic ex, input logic [EW-1:0] e);
    result = r; cycle = cy; data = d; result_valid = 1'b1;
    if (ex) exp_q.push_back(e);
    tick();
    result_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    tick(6);
    check({nm, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(2);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Full-width match, latency 3
    do_cmd(3'd0, 20'h0DCFF);
    do_cmd(3'd1, 20'h098BA);
    send(ln(2, 32'h98BADCFF), 5'd3, 20'h12345, 1'b1, ent(0, 0, 1, 5'd3, 20'h12345));
    tick();
    check("lat_not_yet", 32'(out_valid), 32'd0);
    tick();
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_data", 32'(out_data), 32'(ent(0, 0, 1, 5'd3, 20'h12345)));
    drain("t1");

    // Mask 8: OR across lanes matches, different top byte does not
    do_cmd(3'd2, 20'd8);
    do_cmd(3'd0, 20'h00000);
    do_cmd(3'd1, 20'h0AB00);
    send(ln(1, 32'hA0000000) | ln(3, 32'h0B123456), 5'd7, 20'h00ABC, 1'b1,
         ent(0, 0, 1, 5'd7, 20'h00ABC));
    send(ln(0, 32'hAC000000), 5'd8, 20'h00DEF, 1'b0, '0);
    drain("t2");

    // One-shot sample at cycle 5
    do_cmd(3'd7, 20'h00045);
    for (int i = 0; i < 32; i++)
      send('0, 5'(i), 20'(i), (i == 5), ent(0, 1, 0, 5'd5, 20'd5));
    drain("t3a");
    for (int i = 0; i < 32; i++) send('0, 5'(i), 20'(i), 1'b0, '0);
    drain("t3b");

    // Overflow: DEPTH+3 hits with host stalled
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++)
      send(ln(0, 32'hAB000000), 5'(i), 20'(32'h200 + i), (i < DEPTH),
           ent(0, 0, 1, 5'(i), 20'(32'h200 + i)));
    tick(4);
    check("ovf_drop3", 32'(drop_count), 32'd3);
    check("ovf_valid", 32'(out_valid), 32'd1);
    check("ovf_head", 32'(out_data), 32'(ent(0, 0, 1, 5'd0, 20'h200)));
    tick(3);
    check("ovf_hold", 32'(out_data), 32'(ent(0, 0, 1, 5'd0, 20'h200)));
    drain("t4a");
    send(ln(0, 32'hAB000000), 5'd9, 20'h0F00D, 1'b1, ent(1, 0, 1, 5'd9, 20'h0F00D));
    drain("t4b");

    // Full FIFO, push and pop in the same cycle
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      send(ln(1, 32'hAB000000), 5'(i), 20'(32'h300 + i), 1'b1,
           ent(0, 0, 1, 5'(i), 20'(32'h300 + i)));
    tick(4);
    send(ln(1, 32'hAB000000), 5'd20, 20'h3FF, 1'b1, ent(0, 0, 1, 5'd20, 20'h3FF));
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pp_drop", 32'(drop_count), 32'd3);
    check("pp_valid", 32'(out_valid), 32'd1);
    send(ln(1, 32'hAB000000), 5'd21, 20'h3EE, 1'b0, '0);
    tick(4);
    check("pp_still_full", 32'(drop_count), 32'd4);
    drain("t5");

    // Ignored commands: wrong-ID arm, opcodes 3..6
    do_cmd(3'd7, 20'h00145);
    for (int op = 3; op <= 6; op++) do_cmd(3'(op), 20'h00000);
    send(ln(0, 32'hAB000000), 5'd5, 20'h00055, 1'b1, ent(1, 0, 1, 5'd5, 20'h00055));
    drain("t6a");

    // Back-to-back commands 8 clocks apart
    do_cmd(3'd0, 20'h01111);
    do_cmd(3'd1, 20'h02222);
    do_cmd(3'd2, 20'd32);
    send(ln(3, 32'h22221111), 5'd1, 20'h0AAAA, 1'b1, ent(0, 0, 1, 5'd1, 20'h0AAAA));
    send(ln(3, 32'h22221110), 5'd2, 20'h0BBBB, 1'b0, '0);
    drain("t6b");

    // Reset mid-flight discards in-flight entry and restores defaults
    send(ln(3, 32'h22221111), 5'd3, 20'h0CCCC, 1'b0, '0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(5);
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_drop", 32'(drop_count), 32'd0);
    send('0, 5'd4, 20'h0DDDD, 1'b1, ent(0, 0, 1, 5'd4, 20'h0DDDD));
    drain("t7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
